// File: rtl/mem_byte_access_pkg.sv
// mem_byte_access_pkg: size codes, FSM encoding and code normalisation shared by the MEM-stage access unit.
package mem_byte_access_pkg;
  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_LD_RESP, S_WR, S_RMW_WR, S_ERR} state_t;
  // Unknown size codes behave as full-word accesses.
  function automatic logic [3:0] norm_code(input logic [3:0] c);
    return (c == MASK_HALF || c == MASK_BYTE) ? c : MASK_WORD;
  endfunction
endpackage

// File: rtl/mem_byte_access_load_align.sv
// mem_load_align: little-endian lane select with sign/zero extension for partial loads.
module mem_load_align
  import mem_byte_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [3:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  assign byte_v = word_i[{lane_i, 3'b000} +: 8];
  assign half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];
  assign result_o = (size_i == MASK_BYTE) ? {{24{~unsigned_i & byte_v[7]}}, byte_v} :
                    (size_i == MASK_HALF) ? {{16{~unsigned_i & half_v[15]}}, half_v} :
                    word_i;
endmodule

// File: rtl/mem_byte_access.sv
// mem_byte_access: MEM-stage load/store unit against a synchronous 32-bit RAM; partial stores use read-modify-write.
module mem_byte_access
  import mem_byte_access_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        read_byte,
  input  logic [3:0]        write_byte,
  input  logic              load_unsigned,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misaligned,
  output logic              stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  state_t            state_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q, load_val, merged;
  logic [3:0]        size_q, code_d;
  logic              store_q, uns_q, rdata_valid_q, mis_d;
  logic [4:0]        sh;
  logic              unused_addr;
  assign unused_addr = &{1'b0, addr[31:ADDR_W+2]};
  assign code_d = norm_code(mem_write ? write_byte : read_byte);
  assign mis_d = (code_d == MASK_WORD && addr[1:0] != 2'b00) || (code_d == MASK_HALF && addr[0]);
  // Half accesses reaching RMW are aligned, so the byte shift also positions the half lane.
  assign sh = {addr_q[1:0], 3'b000};
  assign merged = (size_q == MASK_BYTE) ?
                  (ram_rdata & ~(32'h0000_00FF << sh)) | ({24'h0, wdata_q[7:0]} << sh) :
                  (ram_rdata & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata_q[15:0]} << sh);
  assign req_ready   = state_q == S_IDLE;
  assign stall       = state_q != S_IDLE;
  assign misaligned  = state_q == S_ERR;
  assign ram_we      = state_q == S_WR || state_q == S_RMW_WR;
  assign ram_en      = ram_we || state_q == S_RD;
  assign ram_addr    = addr_q[ADDR_W+1:2];
  assign ram_wdata   = (state_q == S_WR) ? wdata_q : (state_q == S_RMW_WR) ? merged : 32'h0;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  mem_load_align u_align (
    .word_i    (ram_rdata),
    .lane_i    (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .result_o  (load_val)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      size_q        <= MASK_WORD;
      store_q       <= 1'b0;
      uns_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid && (mem_read || mem_write)) begin
          addr_q  <= addr[ADDR_W+1:0];
          wdata_q <= wdata;
          size_q  <= code_d;
          store_q <= mem_write;
          uns_q   <= load_unsigned;
          state_q <= mis_d ? S_ERR : (mem_write && code_d == MASK_WORD) ? S_WR : S_RD;
        end
        S_RD: state_q <= store_q ? S_RMW_WR : S_LD_RESP;
        S_LD_RESP: begin
          rdata_q       <= load_val;
          rdata_valid_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_byte_access.sv
// tb_mem_byte_access: directed scoreboard bench with a behavioural synchronous RAM.
module tb_mem_byte_access;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_ready, mem_read = 0, mem_write = 0, load_unsigned = 0;
  logic [3:0]  read_byte = 4'hF, write_byte = 4'hF;
  logic [31:0] addr = 0, wdata = 0, rdata, ram_wdata, ram_rdata = 0;
  logic        rdata_valid, misaligned, stall, ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] mem [0:1023];
  int          checks = 0, errors = 0;
  typedef struct {logic err; logic [31:0] val;} exp_t;
  exp_t exp_q[$];

  mem_byte_access #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .read_byte(read_byte), .write_byte(write_byte),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .misaligned(misaligned), .stall(stall), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && (rdata_valid || misaligned)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got valid=%b mis=%b expected none", rdata_valid, misaligned);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.err !== misaligned || e.err === rdata_valid || (!e.err && rdata !== e.val)) begin
          errors++;
          $display("FAIL scoreboard: got mis=%b valid=%b rdata=%h expected mis=%b rdata=%h",
                   misaligned, rdata_valid, rdata, e.err, e.val);
        end
      end
    end

  // kind: 0 no response, 1 load result, 2 misalignment
  task automatic issue(input string nm, input logic mr, input logic mw, input logic [3:0] code,
                       input logic u, input logic [31:0] a, input logic [31:0] wd,
                       input int kind, input logic [31:0] ev, input int lat);
    int n, st;
    logic saw_en;
    if (kind == 1) exp_q.push_back('{1'b0, ev});
    else if (kind == 2) exp_q.push_back('{1'b1, 32'h0});
    @(negedge clk);
    req_valid = 1; mem_read = mr; mem_write = mw; read_byte = code; write_byte = code;
    load_unsigned = u; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 0; mem_read = 0; mem_write = 0;
    n = 0; st = 0; saw_en = 0;
    while (!req_ready && n < 8) begin
      saw_en |= ram_en;
      st += int'(stall);
      @(posedge clk); #1;
      n++;
    end
    check({nm, " latency"}, n + 1, lat);
    check({nm, " stall_cycles"}, st, lat - 1);
    if (kind == 1) check({nm, " rdata_valid_at_ready"}, {31'b0, rdata_valid}, 1);
    if (kind == 2) check({nm, " no_ram_en"}, {31'b0, saw_en}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    #2;
    check("reset rdata", rdata, 0);
    check("reset flags", {26'b0, rdata_valid, misaligned, stall, ram_en, ram_we, req_ready}, 32'h1);
    check("reset ram_addr", {22'b0, ram_addr}, 0);
    check("reset ram_wdata", ram_wdata, 0);
    @(negedge clk); reset = 0;

    issue("sw", 0, 1, 4'hF, 0, 32'h10, 32'hDEADBEEF, 0, 0, 2);
    check("sw ram", mem[4], 32'hDEADBEEF);
    issue("lw", 1, 0, 4'hF, 0, 32'h10, 0, 1, 32'hDEADBEEF, 3);

    mem[4] = 32'h11223344;
    issue("sb", 0, 1, 4'b0001, 0, 32'h12, 32'h000000AA, 0, 0, 3);
    check("sb ram", mem[4], 32'h11AA3344);
    issue("sh", 0, 1, 4'b0011, 0, 32'h12, 32'h1234BEEF, 0, 0, 3);
    check("sh ram", mem[4], 32'hBEEF3344);

    mem[4] = 32'h80FF7F01;
    issue("lb", 1, 0, 4'b0001, 0, 32'h12, 0, 1, 32'hFFFFFFFF, 3);
    issue("lbu", 1, 0, 4'b0001, 1, 32'h12, 0, 1, 32'h000000FF, 3);
    issue("lh", 1, 0, 4'b0011, 0, 32'h12, 0, 1, 32'hFFFF80FF, 3);
    issue("lhu", 1, 0, 4'b0011, 1, 32'h10, 0, 1, 32'h00007F01, 3);
    issue("lb0", 1, 0, 4'b0001, 0, 32'h10, 0, 1, 32'h00000001, 3);

    issue("lw_mis", 1, 0, 4'hF, 0, 32'h11, 0, 2, 0, 2);
    issue("sh_mis", 0, 1, 4'b0011, 0, 32'h13, 32'h5555, 2, 0, 2);
    check("mis ram", mem[4], 32'h80FF7F01);
    check("rdata hold", rdata, 32'h00000001);

    mem[4] = 32'h11223344;
    @(negedge clk);
    req_valid = 1; mem_write = 1; write_byte = 4'b0001; addr = 32'h11; wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 0; mem_write = 0;
    @(posedge clk); #1;
    check("rst rmw ram_we before", {31'b0, ram_we}, 1);
    reset = 1; #1;
    check("rst rmw ram_we", {31'b0, ram_we}, 0);
    @(posedge clk);
    @(negedge clk); reset = 0; #1;
    check("rst rmw ram", mem[4], 32'h11223344);
    check("rst rmw ready", {31'b0, req_ready}, 1);

    issue("both", 1, 1, 4'hF, 0, 32'h20, 32'hCAFEF00D, 0, 0, 2);
    check("both ram", mem[8], 32'hCAFEF00D);

    @(negedge clk); req_valid = 1;
    @(posedge clk); #1;
    check("noop stall", {31'b0, stall}, 0);
    @(posedge clk); #1;
    check("noop ready", {31'b0, req_ready}, 1);
    req_valid = 0;
    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
